// File: rtl/trigger_arm_ctrl.sv
// Arm/fire/holdoff sequencer between the RVVI frame matcher and the ILA: holds the compare
// pattern, turns a multi-cycle match pulse into one held ILA trigger, and records trigger history.
module trigger_arm_ctrl #(
  parameter int                      NUM_WORDS       = 5,
  parameter logic [32*NUM_WORDS-1:0] DEFAULT_COMPARE = '0,
  parameter int                      ACK_TIMEOUT     = 256,
  parameter int                      HOLDOFF_CYCLES  = 1024
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      CfgWrEn,
  input  logic [2:0]                CfgAddr,
  input  logic [31:0]               CfgWrData,
  input  logic                      Arm,
  input  logic                      Disarm,
  input  logic                      OneShot,
  input  logic                      RawTrigger,
  input  logic [31:0]               TriggerMessage,
  input  logic                      IlaTriggerAck,
  output logic [32*NUM_WORDS-1:0]   CompareString,
  output logic                      IlaTrigger,
  output logic                      Armed,
  output logic                      CfgErr,
  output logic                      TimeoutFlag,
  output logic [15:0]               TriggerCount,
  output logic [31:0]               LastMessage
);
  localparam int MAX_CYC = (ACK_TIMEOUT > HOLDOFF_CYCLES) ? ACK_TIMEOUT : HOLDOFF_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, FIRE, HOLDOFF} state_t;

  state_t                       state;
  logic [TW-1:0]                timer;
  logic                         RawD;
  logic                         trigEdge;
  logic                         cfgOk;
  logic [NUM_WORDS-1:0][31:0]   cmpWords;

  assign trigEdge      = RawTrigger & ~RawD;
  assign cfgOk         = CfgWrEn && (state == IDLE) && (int'(CfgAddr) < NUM_WORDS);
  assign CompareString = cmpWords;
  assign Armed         = (state == ARMED);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      timer        <= '0;
      RawD         <= 1'b0;
      cmpWords     <= DEFAULT_COMPARE;
      IlaTrigger   <= 1'b0;
      CfgErr       <= 1'b0;
      TimeoutFlag  <= 1'b0;
      TriggerCount <= '0;
      LastMessage  <= '0;
    end else begin
      RawD   <= RawTrigger;
      CfgErr <= CfgWrEn && !cfgOk;
      for (int i = 0; i < NUM_WORDS; i++)
        if (cfgOk && int'(CfgAddr) == i) cmpWords[i] <= CfgWrData;
      // Timer free-runs; every state change below restarts it at zero.
      timer <= timer + 1'b1;
      case (state)
        IDLE: begin
          if (Arm) begin
            state       <= ARMED;
            timer       <= '0;
            TimeoutFlag <= 1'b0;
          end
        end
        ARMED: begin
          if (Disarm) begin
            state <= IDLE;
            timer <= '0;
          end else if (trigEdge) begin
            state      <= FIRE;
            timer      <= '0;
            IlaTrigger <= 1'b1;
            if (TriggerCount != 16'hFFFF) TriggerCount <= TriggerCount + 16'd1;
          end
        end
        FIRE: begin
          // Ack has priority over a timeout landing in the same cycle.
          if (IlaTriggerAck || timer == ACK_LAST) begin
            state       <= HOLDOFF;
            timer       <= '0;
            IlaTrigger  <= 1'b0;
            LastMessage <= TriggerMessage;
            if (!IlaTriggerAck) TimeoutFlag <= 1'b1;
          end
        end
        HOLDOFF: begin
          if (Disarm) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == HOLD_LAST) begin
            state <= OneShot ? IDLE : ARMED;
            timer <= '0;
          end
        end
        default: begin
          state      <= IDLE;
          timer      <= '0;
          IlaTrigger <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_trigger_arm_ctrl.sv
// Directed bench for trigger_arm_ctrl with short ack timeout and holdoff windows.
module tb_trigger_arm_ctrl;
  localparam logic [159:0] DEF = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002,
                                  32'hAAAA0001, 32'h99990000};

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         CfgWrEn = 1'b0;
  logic [2:0]   CfgAddr = '0;
  logic [31:0]  CfgWrData = '0;
  logic         Arm = 1'b0, Disarm = 1'b0, OneShot = 1'b0;
  logic         RawTrigger = 1'b0;
  logic [31:0]  TriggerMessage = '0;
  logic         IlaTriggerAck = 1'b0;
  logic [159:0] CompareString;
  logic         IlaTrigger, Armed, CfgErr, TimeoutFlag;
  logic [15:0]  TriggerCount;
  logic [31:0]  LastMessage;

  int total = 0;
  int bad = 0;
  logic [159:0] expCs;

  trigger_arm_ctrl #(
    .NUM_WORDS(5), .DEFAULT_COMPARE(DEF), .ACK_TIMEOUT(4), .HOLDOFF_CYCLES(8)
  ) dut (
    .clk(clk), .resetn(resetn), .CfgWrEn(CfgWrEn), .CfgAddr(CfgAddr), .CfgWrData(CfgWrData),
    .Arm(Arm), .Disarm(Disarm), .OneShot(OneShot), .RawTrigger(RawTrigger),
    .TriggerMessage(TriggerMessage), .IlaTriggerAck(IlaTriggerAck),
    .CompareString(CompareString), .IlaTrigger(IlaTrigger), .Armed(Armed), .CfgErr(CfgErr),
    .TimeoutFlag(TimeoutFlag), .TriggerCount(TriggerCount), .LastMessage(LastMessage)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_cs", CompareString, DEF);
    chk("rst_ila", IlaTrigger, 0);
    chk("rst_armed", Armed, 0);
    chk("rst_cnt", TriggerCount, 0);
    chk("rst_msg", LastMessage, 0);
    chk("rst_to", TimeoutFlag, 0);
    chk("rst_cfgerr", CfgErr, 0);
    resetn = 1'b1;
    tick();

    // Word write in IDLE
    expCs = DEF;
    CfgWrEn = 1; CfgAddr = 3'd2; CfgWrData = 32'h7274005C;
    tick();
    CfgWrEn = 0;
    expCs[95:64] = 32'h7274005C;
    chk("wr2_word", CompareString[95:64], 32'h7274005C);
    chk("wr2_cs", CompareString, expCs);
    chk("wr2_err", CfgErr, 0);

    // Out-of-range address rejected
    CfgWrEn = 1; CfgAddr = 3'd5; CfgWrData = 32'hDEADBEEF;
    tick();
    CfgWrEn = 0;
    chk("addr5_err", CfgErr, 1);
    chk("addr5_cs", CompareString, expCs);
    tick();
    chk("addr5_err_pulse", CfgErr, 0);

    // Arm, then a write while ARMED is rejected
    Arm = 1; tick(); Arm = 0;
    chk("arm", Armed, 1);
    CfgWrEn = 1; CfgAddr = 3'd0; CfgWrData = 32'h12345678;
    tick();
    CfgWrEn = 0;
    chk("wr_armed_err", CfgErr, 1);
    chk("wr_armed_cs", CompareString, expCs);

    // 10-cycle trigger pulse, ack 3 cycles after rise
    RawTrigger = 1; TriggerMessage = 32'hA1A1A1A1;
    tick();
    chk("fire1_ila_c1", IlaTrigger, 1);
    chk("fire1_cnt", TriggerCount, 1);
    tick();
    chk("fire1_ila_c2", IlaTrigger, 1);
    tick();
    chk("fire1_ila_c3", IlaTrigger, 1);
    IlaTriggerAck = 1; TriggerMessage = 32'hB2B2B2B2;
    tick();
    IlaTriggerAck = 0; TriggerMessage = 32'h0000FFFF;
    chk("ack_ila_off", IlaTrigger, 0);
    chk("ack_msg", LastMessage, 32'hB2B2B2B2);
    chk("ack_no_to", TimeoutFlag, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("hold1_ila", IlaTrigger, 0);
    end
    RawTrigger = 0;
    tick();
    chk("hold1_not_armed", Armed, 0);
    tick();
    chk("hold1_rearmed", Armed, 1);
    chk("hold1_cnt", TriggerCount, 1);

    // No ack: timeout after 4 FIRE cycles
    RawTrigger = 1; TriggerMessage = 32'hC3C3C3C3;
    tick();
    RawTrigger = 0; TriggerMessage = 32'hD4D4D4D4;
    chk("to_cnt", TriggerCount, 2);
    for (int i = 0; i < 3; i++) begin
      chk("to_ila_on", IlaTrigger, 1);
      tick();
    end
    chk("to_ila_c4", IlaTrigger, 1);
    tick();
    chk("to_ila_off", IlaTrigger, 0);
    chk("to_flag", TimeoutFlag, 1);
    chk("to_msg", LastMessage, 32'hD4D4D4D4);

    // Rise 3 cycles into holdoff is dropped
    tick(); tick(); tick();
    RawTrigger = 1;
    tick();
    chk("hold_edge_cnt", TriggerCount, 2);
    chk("hold_edge_ila", IlaTrigger, 0);
    RawTrigger = 0;
    tick(); tick(); tick();
    chk("hold2_not_armed", Armed, 0);
    tick();
    chk("hold2_rearmed", Armed, 1);
    RawTrigger = 1;
    tick();
    RawTrigger = 0;
    chk("rearm_cnt", TriggerCount, 3);
    chk("rearm_ila", IlaTrigger, 1);

    // OneShot: ack, holdoff, then back to IDLE
    OneShot = 1; IlaTriggerAck = 1;
    tick();
    IlaTriggerAck = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("oneshot_armed", Armed, 0);
    chk("oneshot_to_sticky", TimeoutFlag, 1);
    CfgWrEn = 1; CfgAddr = 3'd0; CfgWrData = 32'h0BADCAFE;
    tick();
    CfgWrEn = 0; OneShot = 0;
    expCs[31:0] = 32'h0BADCAFE;
    chk("oneshot_idle_wr", CompareString, expCs);
    chk("oneshot_idle_err", CfgErr, 0);

    // Arm + edge in IDLE: armed, no fire, timeout flag cleared
    Arm = 1; RawTrigger = 1;
    tick();
    Arm = 0;
    chk("armedge_armed", Armed, 1);
    chk("armedge_to_clr", TimeoutFlag, 0);
    tick();
    chk("armedge_noila", IlaTrigger, 0);
    chk("armedge_cnt", TriggerCount, 3);
    RawTrigger = 0;
    tick();

    // Disarm wins over edge in ARMED
    Disarm = 1; RawTrigger = 1;
    tick();
    Disarm = 0; RawTrigger = 0;
    chk("disarm_armed", Armed, 0);
    chk("disarm_ila", IlaTrigger, 0);
    chk("disarm_cnt", TriggerCount, 3);

    // Write together with Arm in IDLE applies
    Arm = 1; CfgWrEn = 1; CfgAddr = 3'd4; CfgWrData = 32'hFEEDF00D;
    tick();
    Arm = 0; CfgWrEn = 0;
    expCs[159:128] = 32'hFEEDF00D;
    chk("armwr_cs", CompareString, expCs);
    chk("armwr_armed", Armed, 1);
    chk("armwr_err", CfgErr, 0);

    // Reset during FIRE
    RawTrigger = 1;
    tick();
    RawTrigger = 0;
    chk("prerst_ila", IlaTrigger, 1);
    chk("prerst_cnt", TriggerCount, 4);
    resetn = 0;
    tick();
    chk("firerst_ila", IlaTrigger, 0);
    chk("firerst_cnt", TriggerCount, 0);
    chk("firerst_cs", CompareString, DEF);
    chk("firerst_armed", Armed, 0);
    resetn = 1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
